// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern controller: FSM state encoding,
// default prescaler terminal count and the seed pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_RUN   = 2'b10,
    ST_PAUSE = 2'b11
  } led_state_e;

  // 0.25 s step period at 50 MHz (DIV_MAX+1 clocks per step).
  localparam int LED_DIV_MAX_DEF = 12499999;

  localparam logic [31:0] PAT_ALT = 32'h5555_5555;

  // Seed pattern for a given index, computed 32 bits wide; the caller
  // truncates to the shift register width (width must be 1..32).
  function automatic logic [31:0] led_pattern(input logic [1:0] idx, input int width);
    logic [31:0] p;
    case (idx)
      2'd0:    p = 32'd1;
      2'd1:    p = 32'd3;
      2'd2:    p = PAT_ALT;
      default: p = (32'd1 << (width - 1)) - 32'd1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: counts enabled cycles and emits a one-cycle tick when the
// count equals DIV_MAX, then wraps. Synchronous clear dominates enable.
module led_prescaler
  import led_pkg::*;
#(
  parameter int DIV_W   = 24,
  parameter int DIV_MAX = LED_DIV_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [DIV_W-1:0] MAX_V = DIV_W'(DIV_MAX);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == MAX_V);

  // Next count: clear, hold, increment, or wrap on terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: run/pause/stop FSM with a pattern request/ack
// handshake, one-cycle active-low load strobe and prescaled step enable
// for the downstream rotating shift register.
// Optional build macro LED_AUTO_CYCLE_EN: after 2*CNT_SIZE steps in RUN the
// next pattern is loaded automatically (no pat_ack for that load).
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int CNT_SIZE = 4,
  parameter int DIV_W    = 24,
  parameter int DIV_MAX  = LED_DIV_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic [1:0]          pat_sel,
  input  logic                pat_req,
  output logic                pat_ack,
  output logic                ld_n,
  output logic [CNT_SIZE-1:0] din,
  output logic                step,
  output logic [1:0]          state,
  output logic [7:0]          step_cnt
);

`ifdef LED_AUTO_CYCLE_EN
  localparam logic [7:0] AUTO_LAST = 8'(2 * CNT_SIZE - 1);
`endif

  led_state_e state_q, state_d;
  logic       run_after_q, run_after_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] step_cnt_q, step_cnt_d;
  logic       ack_d;
  logic       pre_en, pre_clr, tick;

  // Prescaler runs only in RUN when no higher-priority event is present;
  // it is cleared while loading and on stop.
  assign pre_en  = (state_q == ST_RUN) && !stop && !pat_req && !pause;
  assign pre_clr = (state_q == ST_LOAD) || stop;

  led_prescaler #(
    .DIV_W  (DIV_W),
    .DIV_MAX(DIV_MAX)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pre_en),
    .clr_i (pre_clr),
    .tick_o(tick)
  );

  // Next state, handshake and pattern latch; priority stop > pat_req > pause > start.
  always_comb begin
    state_d     = state_q;
    run_after_d = run_after_q;
    idx_d       = idx_q;
    ack_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pat_req) begin
          ack_d       = 1'b1;
          idx_d       = pat_sel;
          run_after_d = start;
          state_d     = ST_LOAD;
        end else if (start) begin
          run_after_d = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (stop || !run_after_q) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pat_req) begin
          ack_d       = 1'b1;
          idx_d       = pat_sel;
          run_after_d = 1'b1;
          state_d     = ST_LOAD;
        end else if (pause) begin
          state_d = ST_PAUSE;
`ifdef LED_AUTO_CYCLE_EN
        end else if (tick && (step_cnt_q == AUTO_LAST)) begin
          idx_d       = idx_q + 2'd1;
          run_after_d = 1'b1;
          state_d     = ST_LOAD;
`endif
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pat_req) begin
          ack_d       = 1'b1;
          idx_d       = pat_sel;
          run_after_d = 1'b1;
          state_d     = ST_LOAD;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // Step counter: zeroed on entry to LOAD, advanced on each step.
  always_comb begin
    step_cnt_d = step_cnt_q;
    if (state_d == ST_LOAD) begin
      step_cnt_d = '0;
    end else if (tick) begin
      step_cnt_d = step_cnt_q + 8'd1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      run_after_q <= 1'b0;
      idx_q       <= 2'd0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_after_q <= run_after_d;
      idx_q       <= idx_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  // idx_q only changes on entry to LOAD, so din is stable outside that edge.
  assign din      = CNT_SIZE'(led_pattern(idx_q, CNT_SIZE));
  assign ld_n     = (state_q != ST_LOAD);
  assign step     = tick;
  assign pat_ack  = ack_d && rst_n;
  assign state    = state_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed testbench for led_pattern_ctrl with DIV_MAX=3, CNT_SIZE=4.
// Inputs change 1 ns after the rising edge; outputs are sampled 3 ns after it.
module tb_led_pattern_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, pause, pat_req;
  logic [1:0] pat_sel;
  logic       pat_ack, ld_n, step;
  logic [3:0] din;
  logic [1:0] state;
  logic [7:0] step_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .CNT_SIZE(4),
    .DIV_W   (24),
    .DIV_MAX (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .pat_sel (pat_sel),
    .pat_req (pat_req),
    .pat_ack (pat_ack),
    .ld_n    (ld_n),
    .din     (din),
    .step    (step),
    .state   (state),
    .step_cnt(step_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    pat_req = 1'b0; pat_sel = 2'd0;
    nxt(); nxt();
    settle();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ld_n", 32'(ld_n), 32'd1);
    chk("rst_din", 32'(din), 32'h1);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_ack", 32'(pat_ack), 32'd0);
    chk("rst_step_cnt", 32'(step_cnt), 32'd0);
    nxt();
    rst_n = 1'b1;

    // Start pulse: one LOAD cycle with pattern 0, then steps every 4 cycles.
    nxt();
    start = 1'b1;
    settle();
    chk("start_ack", 32'(pat_ack), 32'd0);
    nxt();
    start = 1'b0;
    settle();
    chk("load_state", 32'(state), 32'd1);
    chk("load_ld_n", 32'(ld_n), 32'd0);
    chk("load_din", 32'(din), 32'h1);
    chk("load_step", 32'(step), 32'd0);
    nxt();
    for (int k = 0; k < 12; k++) begin
      settle();
      chk("run_step", 32'(step), (k % 4 == 3) ? 32'd1 : 32'd0);
      chk("run_ld_n", 32'(ld_n), 32'd1);
      nxt();
    end
    settle();
    chk("run_step_cnt3", 32'(step_cnt), 32'd3);
    chk("run_state", 32'(state), 32'd2);

    // Pattern request from RUN (prescaler at 0).
    pat_sel = 2'd2; pat_req = 1'b1;
    settle();
    chk("req_run_ack", 32'(pat_ack), 32'd1);
    chk("req_run_step", 32'(step), 32'd0);
    nxt();
    pat_req = 1'b0;
    settle();
    chk("req_load_state", 32'(state), 32'd1);
    chk("req_load_ld_n", 32'(ld_n), 32'd0);
    chk("req_load_din", 32'(din), 32'h5);
    chk("req_load_cnt", 32'(step_cnt), 32'd0);
    chk("req_load_ack", 32'(pat_ack), 32'd0);
    nxt();
    settle();
    chk("req_resume_state", 32'(state), 32'd2);

    // Pause for 10 cycles with the prescaler at 2.
    nxt(); nxt();
    pause = 1'b1;
    settle();
    chk("pause_first_step", 32'(step), 32'd0);
    nxt();
    for (int k = 0; k < 9; k++) begin
      settle();
      chk("pause_state", 32'(state), 32'd3);
      chk("pause_step", 32'(step), 32'd0);
      nxt();
    end
    pause = 1'b0;
    settle();
    chk("release_step0", 32'(step), 32'd0);
    nxt();
    settle();
    chk("release_step1", 32'(step), 32'd0);
    chk("release_state", 32'(state), 32'd2);
    nxt();
    settle();
    chk("release_step2", 32'(step), 32'd1);
    nxt();
    settle();
    chk("release_cnt", 32'(step_cnt), 32'd1);

    // stop + pat_req + start together: stop wins.
    stop = 1'b1; pat_req = 1'b1; start = 1'b1; pat_sel = 2'd1;
    settle();
    chk("stop_ack", 32'(pat_ack), 32'd0);
    chk("stop_step", 32'(step), 32'd0);
    nxt();
    stop = 1'b0; pat_req = 1'b0; start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("stop_idle_state", 32'(state), 32'd0);
      chk("stop_idle_ld_n", 32'(ld_n), 32'd1);
      chk("stop_idle_step", 32'(step), 32'd0);
      chk("stop_idle_din", 32'(din), 32'h5);
      nxt();
    end

    // Preview load from IDLE; request held into LOAD is not acked there.
    pat_sel = 2'd3; pat_req = 1'b1;
    settle();
    chk("idle_req_ack", 32'(pat_ack), 32'd1);
    nxt();
    settle();
    chk("idle_load_state", 32'(state), 32'd1);
    chk("idle_load_ld_n", 32'(ld_n), 32'd0);
    chk("idle_load_din", 32'(din), 32'h7);
    chk("load_ignores_req", 32'(pat_ack), 32'd0);
    pat_req = 1'b0;
    nxt();
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("preview_state", 32'(state), 32'd0);
      chk("preview_step", 32'(step), 32'd0);
      chk("preview_ld_n", 32'(ld_n), 32'd1);
      nxt();
    end

    // start with pat_req in IDLE runs after load; pause during LOAD goes to PAUSE.
    pat_sel = 2'd0; pat_req = 1'b1; start = 1'b1;
    settle();
    chk("reqstart_ack", 32'(pat_ack), 32'd1);
    nxt();
    pat_req = 1'b0; start = 1'b0; pause = 1'b1;
    settle();
    chk("reqstart_din", 32'(din), 32'h1);
    chk("reqstart_ld_n", 32'(ld_n), 32'd0);
    nxt();
    settle();
    chk("load_to_pause", 32'(state), 32'd3);
    pause = 1'b0;
    nxt();
    settle();
    chk("pause_to_run", 32'(state), 32'd2);
    stop = 1'b1;
    nxt();
    stop = 1'b0;
    settle();
    chk("stop_from_run", 32'(state), 32'd0);

    // Run pattern 0 through 8 steps.
    start = 1'b1;
    nxt();
    start = 1'b0;
    nxt();
    for (int k = 0; k < 32; k++) begin
      settle();
      chk("long_step", 32'(step), (k % 4 == 3) ? 32'd1 : 32'd0);
      chk("long_ack", 32'(pat_ack), 32'd0);
      nxt();
    end
    settle();
`ifdef LED_AUTO_CYCLE_EN
    chk("auto_state", 32'(state), 32'd1);
    chk("auto_ld_n", 32'(ld_n), 32'd0);
    chk("auto_din", 32'(din), 32'h3);
    chk("auto_ack", 32'(pat_ack), 32'd0);
    chk("auto_cnt", 32'(step_cnt), 32'd0);
`else
    chk("noauto_state", 32'(state), 32'd2);
    chk("noauto_din", 32'(din), 32'h1);
    chk("noauto_cnt", 32'(step_cnt), 32'd8);
`endif

    // Asynchronous reset mid-run.
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_ld_n", 32'(ld_n), 32'd1);
    chk("arst_din", 32'(din), 32'h1);
    chk("arst_cnt", 32'(step_cnt), 32'd0);
    chk("arst_step", 32'(step), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Control stage directly upstream of the LED rotating shift register.
- Selects one of four built-in seed patterns and drives them onto the register's parallel-load input.
- Issues a one-cycle active-low load strobe, and a prescaled step enable that paces each rotation.
- Runs a small run/pause/stop state machine with a request/acknowledge handshake for pattern changes.

Parameters:
- CNT_SIZE, 4: width of the pattern and of the downstream shift register.
- DIV_W, 24: prescaler counter width.
- DIV_MAX, 12499999: prescaler terminal count; step period is DIV_MAX+1 clocks (0.25 s at 50 MHz).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begin running from IDLE.
- stop  in  1  pulse; return to IDLE.
- pause  in  1  level; while high, stepping is frozen.
- pat_sel  in  2  pattern index, sampled when a request is accepted.
- pat_req  in  1  request to load the pattern selected by pat_sel.
- pat_ack  out  1  one-cycle acceptance of pat_req.
- ld_n  out  1  one-cycle active-low load strobe to the shift register.
- din  out  CNT_SIZE  seed pattern; valid and stable whenever ld_n is low.
- step  out  1  one-cycle shift enable.
- state  out  2  current FSM state (debug).
- step_cnt  out  8  steps since the last load; wraps at 255.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values:
  - state=IDLE, ld_n=1, din=pattern 0, step=0, pat_ack=0, step_cnt=0.
  - Prescaler=0; internal run_after=0.
- Patterns:
  - 0: value 1.
  - 1: value 3.
  - 2: alternating ...0101 (LSB=1).
  - 3: all ones except the MSB.
  - All patterns are truncated or extended to CNT_SIZE bits.
- States: IDLE=00, LOAD=01, RUN=10, PAUSE=11.
- IDLE:
  - pat_req -> LOAD with run_after=0 (preview load).
  - Otherwise start -> LOAD with run_after=1, using the pattern index currently held.
- LOAD:
  - Lasts exactly one cycle; ld_n=0 and din holds the latched pattern.
  - Prescaler and step_cnt are cleared.
  - Next state: run_after=0 -> IDLE; pause high -> PAUSE; otherwise RUN.
- RUN:
  - Prescaler increments each cycle. When it equals DIV_MAX, step=1 for that cycle, the prescaler wraps to 0, and step_cnt increments.
  - First step occurs DIV_MAX+1 cycles after leaving LOAD.
  - pause -> PAUSE, with no step in that cycle.
- PAUSE:
  - Prescaler and step_cnt hold; step=0.
  - pause low -> RUN, counting resumes from the held value.
- Pattern request handshake:
  - pat_req is accepted in IDLE, RUN or PAUSE.
  - On acceptance: pat_ack=1 in that cycle, pat_sel is latched, next state LOAD.
  - run_after=1 if the request came from RUN or PAUSE.
  - pat_req is ignored (no ack) while in LOAD. The requester holds pat_req until it sees pat_ack.
- Priority when events coincide in one cycle: stop > pat_req > pause > start.
  - stop: next state IDLE, prescaler cleared, step=0, any pat_req in that cycle is not acked.
  - start together with pat_req in IDLE: treated as a request with run_after=1.
- step and ld_n are never active in the same cycle.
- din changes only on entry to LOAD.
- Reset asserted mid-operation: all outputs immediately return to their reset values.

Optional Feature:
- Macro: LED_AUTO_CYCLE_EN.
- Defined:
  - In RUN, when step_cnt reaches 2*CNT_SIZE on a step, the block enters LOAD with pattern index+1 (3 wraps to 0) and run_after=1. No pat_ack is generated.
  - A user pat_req in the same cycle takes priority.
- Undefined: patterns change only through pat_req.

Decomposition:
- Package led_pkg holds:
  - the state encoding constants;
  - the four pattern constants or a pattern function parameterised by CNT_SIZE;
  - the default DIV_MAX.
- One sub-module, led_prescaler: enable, synchronous clear, DIV_MAX compare, tick output. The FSM and handshake stay in the top.

Test Plan (DIV_MAX=3, CNT_SIZE=4):
- Reset, then start pulse -> one cycle LOAD with ld_n=0, din=0001; step pulses every 4 cycles; step_cnt reaches 3 after 12 cycles.
- In RUN, pat_sel=2 with pat_req held -> pat_ack for one cycle, next cycle ld_n=0 with din=0101, step_cnt=0, run continues.
- pause high for 10 cycles with prescaler at 2 -> no step; after release, step occurs 2 cycles later.
- stop, pat_req and start asserted in the same cycle -> state=IDLE, no ack, no load, step stays 0.
- In IDLE, pat_req with pat_sel=3 -> ack, load din=0111, return to IDLE, no steps.
- With LED_AUTO_CYCLE_EN defined, pattern 0 running -> after 8 steps, automatic load of din=0011 and no pat_ack.
